// File: rtl/me_sad_select.sv
// me_sad_select
// Minimum-SAD selector and search sequencer for the motion-estimation datapath.
// Each accepted beat carries LANES candidate SADs with their motion vectors.
// The block keeps the running minimum over NUM_CAND candidates and reports the
// winner through a req/ack handshake.
//
// Ports
//   clk, rst_n   : rising-edge clock, synchronous active-low reset
//   req          : search request, level-held by the master until it sees ack
//   ack          : result valid (DONE state)
//   busy         : search in progress (RUN state)
//   cand_valid   : beat strobe, honoured only in RUN
//   cand_sad     : lane i at [i*SAD_W +: SAD_W]
//   cand_mvec    : lane i {h,w} at [i*2*MV_W +: 2*MV_W]
//   min_sad      : true (unbiased) SAD of the current best candidate
//   min_mvec     : {h,w} of the current best candidate
//   dbg_state    : current FSM state, for observation only
//
// Handshake: req rises -> RUN. After NUM_CAND candidates -> DONE, ack=1.
// The master drops req -> IDLE, and ack falls on that edge. Dropping req
// while in RUN aborts the search: ack never rises and the partial result is
// kept.
module me_sad_select #(
  parameter int                  SAD_W     = 16,
  parameter int                  MV_W      = 5,
  parameter int                  LANES     = 4,
  parameter int                  NUM_CAND  = 256,
  parameter logic [2*MV_W-1:0]   ZERO_MV   = '0,
  parameter logic [SAD_W-1:0]    ZERO_BIAS = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  output logic                      ack,
  output logic                      busy,
  input  logic                      cand_valid,
  input  logic [LANES*SAD_W-1:0]    cand_sad,
  input  logic [LANES*2*MV_W-1:0]   cand_mvec,
  output logic [SAD_W-1:0]          min_sad,
  output logic [2*MV_W-1:0]         min_mvec,
  output logic [1:0]                dbg_state
);

  localparam int CNT_W = $clog2(NUM_CAND + 1);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CAND);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [SAD_W-1:0]     best_key_q;
  logic [SAD_W-1:0]     min_sad_q;
  logic [2*MV_W-1:0]    min_mvec_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;

  // Lane winner of the current beat.
  logic [SAD_W-1:0]     win_key;
  logic [SAD_W-1:0]     win_sad;
  logic [2*MV_W-1:0]    win_mv;

  // Lane reduction. The strict '<' keeps the lower lane on equal keys.
  // The zero-vector credit only affects the key; the true SAD travels with it.
  always_comb begin : lane_reduce
    logic [SAD_W-1:0]  l_sad;
    logic [SAD_W-1:0]  l_key;
    logic [2*MV_W-1:0] l_mv;
    win_key = '1;
    win_sad = '1;
    win_mv  = '0;
    l_sad   = '0;
    l_key   = '0;
    l_mv    = '0;
    for (int i = 0; i < LANES; i++) begin
      l_sad = cand_sad[i*SAD_W +: SAD_W];
      l_mv  = cand_mvec[i*2*MV_W +: 2*MV_W];
      if (l_mv == ZERO_MV) begin
        l_key = (l_sad > ZERO_BIAS) ? (l_sad - ZERO_BIAS) : '0;
      end else begin
        l_key = l_sad;
      end
      if (i == 0 || l_key < win_key) begin
        win_key = l_key;
        win_sad = l_sad;
        win_mv  = l_mv;
      end
    end
  end

  assign cnt_d = cnt_q + CNT_STEP;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      best_key_q <= '1;
      min_sad_q  <= '1;
      min_mvec_q <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q    <= S_RUN;
            best_key_q <= '1;
            min_sad_q  <= '1;
            min_mvec_q <= '0;
            cnt_q      <= '0;
          end
        end
        S_RUN: begin
          if (!req) begin
            // Abort: the partial result stays visible.
            state_q <= S_IDLE;
          end else if (cand_valid) begin
            // Strict '<' lets the earliest beat win a tie across beats.
            if (win_key < best_key_q) begin
              best_key_q <= win_key;
              min_sad_q  <= win_sad;
              min_mvec_q <= win_mv;
            end
            cnt_q <= cnt_d;
            if (cnt_d == CNT_LAST) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!req) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack       = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign min_sad   = min_sad_q;
  assign min_mvec  = min_mvec_q;
  assign dbg_state = state_q;

endmodule

// File: doc/me_sad_select.md
# me_sad_select

Parametrised minimum-SAD selector and search sequencer for the motion estimation datapath. It sits between the PE/PA array outputs and the `me_*` top-level result ports. Each beat it accepts `LANES` candidate SADs with their motion vectors, reduces them to the running minimum over a full search of `NUM_CAND` candidates, and reports the winner through the same `req`/`ack` handshake the ME top level exposes. It generalises the single-path minimum tracking of the double ME core in three ways: configurable lane count and widths, an optional zero-vector bias, and abort on `req` withdrawal.

## Interface
Parameters:
- `SAD_W`, default 16: SAD width in bits.
- `MV_W`, default 5: width of each motion-vector component (h, w).
- `LANES`, default 4: candidates presented per beat.
- `NUM_CAND`, default 256: candidates per search. Must be a multiple of `LANES` and at least `LANES`.
- `ZERO_MV`, default 10'd0: packed {h,w} vector that receives the bias.
- `ZERO_BIAS`, default 0: SAD credit applied to the `ZERO_MV` candidate in comparisons only.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `req`, in, 1: search request; level-held by the master until it sees `ack`, then released.
- `ack`, out, 1: result valid.
- `busy`, out, 1: high in RUN.
- `cand_valid`, in, 1: beat strobe.
- `cand_sad`, in, LANES*SAD_W: lane i occupies bits [i*SAD_W +: SAD_W].
- `cand_mvec`, in, LANES*2*MV_W: lane i is {h,w} at bits [i*2*MV_W +: 2*MV_W].
- `min_sad`, out, SAD_W: true (unbiased) SAD of the winner.
- `min_mvec`, out, 2*MV_W: {h,w} of the winner.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE → RUN** when `req`=1.
  - On that edge: `best_key`←all-ones, `min_sad`←all-ones, `min_mvec`←0, `cnt`←0.
- **Compare key:**
  - For a `ZERO_MV` candidate: `key = sad − ZERO_BIAS`, saturating at 0, SAD_W bits.
  - For any other candidate: `key = sad`.
  - Stored results are always the true SAD, never the key.
- **Lane reduction** (combinational): pick the minimum key across lanes. On equal keys the lower lane index wins.
- **Running update:** in RUN, on a beat with `cand_valid`=1, the lane winner replaces the best only if `key < best_key` (strictly). On ties the earliest beat wins.
- **Beat counter:** in RUN, each `cand_valid` beat does `cnt += LANES`.
  - The beat that makes `cnt == NUM_CAND` also applies its update and moves the FSM to DONE.
  - `cnt` width is clog2(NUM_CAND+1).
- **DONE:** `ack`=1 and outputs frozen.
  - DONE → IDLE when `req`=0; `ack` drops on that edge.
- **Ignored beats:** `cand_valid` in IDLE or DONE has no effect.
- **Abort:** `req`=0 in RUN → IDLE next edge.
  - `ack` never asserts.
  - `min_sad`/`min_mvec` keep the partial values.
- **`cand_valid` gaps** in RUN stall the count. There is no timeout.
- **Reset state:** IDLE, `ack`=0, `busy`=0, `min_sad`=all-ones, `min_mvec`=0, `cnt`=0.
  - Reset takes effect mid-search with the same values.

## Timing
- **Req to start:** `req` sampled high at edge t → `busy`=1 from t. Earliest accepted beat is at edge t+1.
- **Last beat to ack:** last beat sampled at edge t → `ack`=1 and final `min_*` visible after t, i.e. in cycle t+1. The pipeline adds no further latency.
- **Ack release:** `req` sampled low at edge t in DONE → `ack`=0 after t.
- **Back-to-back:** a new search may start the edge after returning to IDLE. If `req` is still high in IDLE it restarts immediately.
- **Throughput:** one beat per cycle; minimum search length is NUM_CAND/LANES cycles.

## Test plan
1. **Basic search.** LANES=4, NUM_CAND=16. Four beats; the unique minimum is sad 37 at lane 2 of beat 3, mvec {3,9}. Expect `ack` one cycle after beat 4, `min_sad`=37, `min_mvec`={3,9}.
2. **Ties.** Sad 20 on lanes 1 and 3 of beat 1, and sad 20 again in beat 2. Expect the beat 1 lane 1 vector.
3. **Zero bias.** ZERO_BIAS=8, ZERO_MV={0,0}. Zero vector has sad 45; another candidate has sad 40. Expect `min_mvec`={0,0`} and `min_sad`=45. With sad 36 on the other candidate, expect that candidate with `min_sad`=36. With ZERO_BIAS > sad, the key saturates to 0 and no wrap occurs.
4. **Stalls and ignored beats.** Insert `cand_valid` gaps mid-search and drive beats while in IDLE and DONE. Expect the count and result unaffected, and `ack` timing relative to the 4th accepted beat only.
5. **Abort and reset.** Drop `req` after 2 beats → IDLE with no `ack`; a following full search gives a correct result. Assert `rst_n`=0 mid-search → all outputs return to their reset values on the next edge.
6. **All-ones SAD.** All candidates have sad = 16'hFFFF. Expect `min_sad`=FFFF and `min_mvec` = beat 0 lane 0 only if its key is strictly below the initial all-ones. Otherwise `min_mvec` stays 0, which is the decided behaviour.
